// File: rtl/datapath_seq_pkg.sv
// ============================================================================
// Module   : datapath_seq_pkg
// Brief    : Shared encodings for the datapath_seq instruction set.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package datapath_seq_pkg;

    // Opcodes, instruction bits [15:13]
    localparam logic [2:0] c_OP_MOV  = 3'd0;
    localparam logic [2:0] c_OP_ADD  = 3'd1;
    localparam logic [2:0] c_OP_SUB  = 3'd2;
    localparam logic [2:0] c_OP_AND  = 3'd3;
    localparam logic [2:0] c_OP_OR   = 3'd4;
    localparam logic [2:0] c_OP_XOR  = 3'd5;
    localparam logic [2:0] c_OP_BR   = 3'd6;
    localparam logic [2:0] c_OP_HALT = 3'd7;

    // Branch conditions, instruction bits [12:10] when opcode is BR
    localparam logic [2:0] c_CC_ALWAYS = 3'd0;
    localparam logic [2:0] c_CC_Z      = 3'd1;
    localparam logic [2:0] c_CC_NZ     = 3'd2;
    localparam logic [2:0] c_CC_C      = 3'd3;
    localparam logic [2:0] c_CC_NC     = 3'd4;
    localparam logic [2:0] c_CC_N      = 3'd5;
    localparam logic [2:0] c_CC_CALL   = 3'd6;
    localparam logic [2:0] c_CC_RET    = 3'd7;

    // Source selects, instruction bits [12:10] for ALU opcodes
    localparam logic [2:0] c_SRC_A     = 3'd0;
    localparam logic [2:0] c_SRC_R1    = 3'd1;
    localparam logic [2:0] c_SRC_R2    = 3'd2;
    localparam logic [2:0] c_SRC_R3    = 3'd3;
    localparam logic [2:0] c_SRC_X     = 3'd4;
    localparam logic [2:0] c_SRC_IMM   = 3'd5;
    localparam logic [2:0] c_SRC_ONE   = 3'd6;
    localparam logic [2:0] c_SRC_CARRY = 3'd7;

    localparam logic [1:0] c_DST_A  = 2'd0;
    localparam logic [1:0] c_DST_R1 = 2'd1;
    localparam logic [1:0] c_DST_R2 = 2'd2;
    localparam logic [1:0] c_DST_R3 = 2'd3;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    localparam int c_OP_MSB  = 15;
    localparam int c_OP_LSB  = 13;
    localparam int c_SEL_MSB = 12;
    localparam int c_SEL_LSB = 10;
    localparam int c_DST_MSB = 9;
    localparam int c_DST_LSB = 8;
    localparam int c_IMM_MSB = 7;
    localparam int c_IMM_LSB = 0;

endpackage

`default_nettype wire

// File: rtl/alu_param.sv
// ============================================================================
// Module   : alu_param
// Brief    : Combinational DATA_W-wide ALU producing a result and {V,C,N,Z}.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_param
    import datapath_seq_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [2:0]        i_op,
    output logic [DATA_W-1:0] o_r,
    output logic [3:0]        o_flags
);

    localparam int c_MSB = DATA_W - 1;

    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_diff;
    logic [DATA_W-1:0] w_r;
    logic              w_c;
    logic              w_v;

    // The extra top bit holds carry-out for ADD and borrow (A<B) for SUB.
    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    always_comb begin
        w_r = '0;
        w_c = 1'b0;
        w_v = 1'b0;
        case (i_op)
            c_OP_MOV: w_r = i_b;
            c_OP_ADD: begin
                w_r = w_sum[DATA_W-1:0];
                w_c = w_sum[DATA_W];
                w_v = (i_a[c_MSB] == i_b[c_MSB]) && (w_sum[c_MSB] != i_a[c_MSB]);
            end
            c_OP_SUB: begin
                w_r = w_diff[DATA_W-1:0];
                w_c = w_diff[DATA_W];
                w_v = (i_a[c_MSB] != i_b[c_MSB]) && (w_diff[c_MSB] != i_a[c_MSB]);
            end
            c_OP_AND: w_r = i_a & i_b;
            c_OP_OR:  w_r = i_a | i_b;
            c_OP_XOR: w_r = i_a ^ i_b;
            default:  w_r = '0;
        endcase
    end

    assign o_r             = w_r;
    assign o_flags[FLAG_Z] = (w_r == '0);
    assign o_flags[FLAG_N] = w_r[c_MSB];
    assign o_flags[FLAG_C] = w_c;
    assign o_flags[FLAG_V] = w_v;

endmodule

`default_nettype wire

// File: rtl/datapath_seq.sv
// ============================================================================
// Module   : datapath_seq
// Brief    : Single-cycle accumulator datapath with pc, branches and halt.
// Options  : DATAPATH_CALL_STACK_EN compiles in the STACK_D-deep call stack.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module datapath_seq
    import datapath_seq_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 5,
    parameter int STACK_D = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic [DATA_W-1:0] X,
    input  logic [15:0]       instr,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] R1,
    output logic [DATA_W-1:0] R2,
    output logic [DATA_W-1:0] R3,
    output logic [3:0]        FLAGS,
    output logic              halted,
    output logic              err
);

    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_r1;
    logic [DATA_W-1:0] r_r2;
    logic [DATA_W-1:0] r_r3;
    logic [3:0]        r_flags;
    logic              r_halted;
    logic              r_err;

    logic [2:0]        w_op;
    logic [2:0]        w_sel;
    logic [1:0]        w_dst;
    logic [7:0]        w_imm;
    logic [DATA_W-1:0] w_src;
    logic [DATA_W-1:0] w_alu_r;
    logic [3:0]        w_alu_flags;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_br_pc;
    logic              w_taken;
    logic              w_stk_err;

    assign w_op  = instr[c_OP_MSB:c_OP_LSB];
    assign w_sel = instr[c_SEL_MSB:c_SEL_LSB];
    assign w_dst = instr[c_DST_MSB:c_DST_LSB];
    assign w_imm = instr[c_IMM_MSB:c_IMM_LSB];

    assign w_pc_inc = r_pc + ADDR_W'(1);
    assign w_target = ADDR_W'(w_imm);

    always_comb begin
        w_src = '0;
        case (w_sel)
            c_SRC_A:     w_src = r_a;
            c_SRC_R1:    w_src = r_r1;
            c_SRC_R2:    w_src = r_r2;
            c_SRC_R3:    w_src = r_r3;
            c_SRC_X:     w_src = X;
            c_SRC_IMM:   w_src = DATA_W'(w_imm);
            c_SRC_ONE:   w_src = DATA_W'(1);
            c_SRC_CARRY: w_src = DATA_W'(r_flags[FLAG_C]);
            default:     w_src = '0;
        endcase
    end

    alu_param #(
        .DATA_W (DATA_W)
    ) u_alu (
        .i_a     (r_a),
        .i_b     (w_src),
        .i_op    (w_op),
        .o_r     (w_alu_r),
        .o_flags (w_alu_flags)
    );

    // Conditions look at the committed FLAGS, never at this cycle's ALU output.
    always_comb begin
        w_taken = 1'b0;
        case (w_sel)
            c_CC_ALWAYS:         w_taken = 1'b1;
            c_CC_Z:              w_taken = r_flags[FLAG_Z];
            c_CC_NZ:             w_taken = !r_flags[FLAG_Z];
            c_CC_C:              w_taken = r_flags[FLAG_C];
            c_CC_NC:             w_taken = !r_flags[FLAG_C];
            c_CC_N:              w_taken = r_flags[FLAG_N];
            c_CC_CALL, c_CC_RET: w_taken = 1'b0;
            default:             w_taken = 1'b0;
        endcase
    end

`ifdef DATAPATH_CALL_STACK_EN
    localparam int c_SP_W = $clog2(STACK_D + 1);

    // Shift-register LIFO: entry 0 is always the top of stack.
    logic [ADDR_W-1:0] r_stack [STACK_D];
    logic [c_SP_W-1:0] r_sp;
    logic              w_exec_br;
    logic              w_call;
    logic              w_ret;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;

    assign w_exec_br = run && !r_halted && (w_op == c_OP_BR);
    assign w_call    = w_exec_br && (w_sel == c_CC_CALL);
    assign w_ret     = w_exec_br && (w_sel == c_CC_RET);
    assign w_full    = (r_sp == c_SP_W'(STACK_D));
    assign w_empty   = (r_sp == '0);
    assign w_push    = w_call && !w_full;
    assign w_pop     = w_ret && !w_empty;
    assign w_stk_err = (w_call && w_full) || (w_ret && w_empty);

    always_comb begin
        w_br_pc = w_taken ? w_target : w_pc_inc;
        if (w_sel == c_CC_CALL) begin
            w_br_pc = w_target;
        end else if (w_sel == c_CC_RET) begin
            w_br_pc = r_stack[0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sp <= '0;
            for (int i = 0; i < STACK_D; i++) begin
                r_stack[i] <= '0;
            end
        end else if (w_push) begin
            r_stack[0] <= w_pc_inc;
            for (int i = 1; i < STACK_D; i++) begin
                r_stack[i] <= r_stack[i-1];
            end
            r_sp <= r_sp + c_SP_W'(1);
        end else if (w_pop) begin
            for (int i = 0; i < STACK_D - 1; i++) begin
                r_stack[i] <= r_stack[i+1];
            end
            r_sp <= r_sp - c_SP_W'(1);
        end
    end
`else
    // Depth only matters when the stack is compiled in.
    localparam int c_unused_stack_d = STACK_D;

    assign w_stk_err = 1'b0;
    assign w_br_pc   = w_taken ? w_target : w_pc_inc;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc     <= '0;
            r_a      <= '0;
            r_r1     <= '0;
            r_r2     <= '0;
            r_r3     <= '0;
            r_flags  <= '0;
            r_halted <= 1'b0;
            r_err    <= 1'b0;
        end else if (run && !r_halted) begin
            case (w_op)
                c_OP_BR: begin
                    if (w_stk_err) begin
                        r_err    <= 1'b1;
                        r_halted <= 1'b1;
                    end else begin
                        r_pc <= w_br_pc;
                    end
                end
                c_OP_HALT: r_halted <= 1'b1;
                default: begin
                    r_pc    <= w_pc_inc;
                    r_flags <= w_alu_flags;
                    case (w_dst)
                        c_DST_A:  r_a  <= w_alu_r;
                        c_DST_R1: r_r1 <= w_alu_r;
                        c_DST_R2: r_r2 <= w_alu_r;
                        c_DST_R3: r_r3 <= w_alu_r;
                        default:  r_a  <= w_alu_r;
                    endcase
                end
            endcase
        end
    end

    assign pc     = r_pc;
    assign A      = r_a;
    assign R1     = r_r1;
    assign R2     = r_r2;
    assign R3     = r_r3;
    assign FLAGS  = r_flags;
    assign halted = r_halted;
    assign err    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_datapath_seq.sv
// ============================================================================
// Module   : tb_datapath_seq
// Brief    : Scoreboard bench for datapath_seq (stack checks follow the
//            DATAPATH_CALL_STACK_EN macro).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_datapath_seq;

    localparam int c_DATA_W  = 8;
    localparam int c_ADDR_W  = 5;
    localparam int c_STACK_D = 2;

    localparam logic [2:0] c_MOV = 3'd0, c_ADD = 3'd1, c_SUB = 3'd2, c_AND = 3'd3;
    localparam logic [2:0] c_OR  = 3'd4, c_XOR = 3'd5, c_BR  = 3'd6, c_HLT = 3'd7;
    localparam logic [2:0] c_S_A = 3'd0, c_S_R1 = 3'd1, c_S_R2 = 3'd2;
    localparam logic [2:0] c_S_X = 3'd4, c_S_IMM = 3'd5, c_S_ONE = 3'd6;
    localparam logic [2:0] c_C_AL = 3'd0, c_C_Z = 3'd1, c_C_NZ = 3'd2, c_C_C = 3'd3;
    localparam logic [2:0] c_C_NC = 3'd4, c_C_N = 3'd5, c_C_CALL = 3'd6, c_C_RET = 3'd7;
    localparam logic [1:0] c_D_A = 2'd0, c_D_R1 = 2'd1, c_D_R2 = 2'd2, c_D_R3 = 2'd3;

    localparam int c_K_PC = 0, c_K_A = 1, c_K_R1 = 2, c_K_R2 = 3;
    localparam int c_K_FLAGS = 4, c_K_HALTED = 5, c_K_ERR = 6;

    logic                r_clock;
    logic                r_reset;
    logic                r_run;
    logic [c_DATA_W-1:0] r_x;
    logic [15:0]         w_instr;
    logic [c_ADDR_W-1:0] w_pc;
    logic [c_DATA_W-1:0] w_a, w_r1, w_r2, w_r3;
    logic [3:0]          w_flags;
    logic                w_halted;
    logic                w_err;

    logic [15:0] rom [32];

    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp;
    int   n_bad;

    datapath_seq #(
        .DATA_W  (c_DATA_W),
        .ADDR_W  (c_ADDR_W),
        .STACK_D (c_STACK_D)
    ) dut (
        .clock  (r_clock),
        .reset  (r_reset),
        .run    (r_run),
        .X      (r_x),
        .instr  (w_instr),
        .pc     (w_pc),
        .A      (w_a),
        .R1     (w_r1),
        .R2     (w_r2),
        .R3     (w_r3),
        .FLAGS  (w_flags),
        .halted (w_halted),
        .err    (w_err)
    );

    assign w_instr = rom[w_pc];

    initial r_clock = 1'b0;
    always #5 r_clock = ~r_clock;

    function automatic logic [15:0] ins(input logic [2:0] op, input logic [2:0] sel,
                                        input logic [1:0] dst, input logic [7:0] imm);
        return {op, sel, dst, imm};
    endfunction

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            c_K_PC:     return 32'(w_pc);
            c_K_A:      return 32'(w_a);
            c_K_R1:     return 32'(w_r1);
            c_K_R2:     return 32'(w_r2);
            c_K_FLAGS:  return 32'(w_flags);
            c_K_HALTED: return 32'(w_halted);
            c_K_ERR:    return 32'(w_err);
            default:    return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_val(input string tag, input int kind, input logic [31:0] val);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.val  = val;
        sb.push_back(e);
    endtask

    // One clock edge, then drain every expectation queued for it.
    task automatic step();
        @(posedge r_clock);
        #1;
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check(e.tag, observe(e.kind), e.val);
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 32; i++) rom[i] = ins(c_HLT, 3'd0, 2'd0, 8'd0);
    endtask

    task automatic do_reset(input string tag);
        r_reset = 1'b1;
        expect_val({tag, "_rst_pc"}, c_K_PC, 0);
        expect_val({tag, "_rst_a"}, c_K_A, 0);
        expect_val({tag, "_rst_flags"}, c_K_FLAGS, 0);
        expect_val({tag, "_rst_halted"}, c_K_HALTED, 0);
        expect_val({tag, "_rst_err"}, c_K_ERR, 0);
        step();
        r_reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        r_reset = 1'b1;
        r_run   = 1'b1;
        r_x     = 8'hA5;

        // MOV/ADD into signed overflow
        clear_rom();
        rom[0] = ins(c_MOV, c_S_IMM, c_D_A, 8'h7F);
        rom[1] = ins(c_ADD, c_S_ONE, c_D_A, 8'h00);
        do_reset("t1");
        expect_val("t1_mov_a", c_K_A, 8'h7F);
        expect_val("t1_mov_flags", c_K_FLAGS, 4'b0000);
        step();
        expect_val("t1_add_a", c_K_A, 8'h80);
        expect_val("t1_add_flags", c_K_FLAGS, 4'b1010);
        expect_val("t1_pc", c_K_PC, 2);
        step();

        // SUB borrow, ADD carry to zero, logic ops, X source, SUB overflow
        clear_rom();
        rom[0] = ins(c_MOV, c_S_IMM, c_D_A, 8'h03);
        rom[1] = ins(c_SUB, c_S_IMM, c_D_A, 8'h05);
        rom[2] = ins(c_ADD, c_S_IMM, c_D_A, 8'h02);
        rom[3] = ins(c_OR,  c_S_IMM, c_D_A, 8'h0F);
        rom[4] = ins(c_XOR, c_S_IMM, c_D_A, 8'h0F);
        rom[5] = ins(c_MOV, c_S_X,   c_D_R2, 8'h00);
        rom[6] = ins(c_MOV, c_S_R2,  c_D_A, 8'h00);
        rom[7] = ins(c_AND, c_S_IMM, c_D_A, 8'h3C);
        rom[8] = ins(c_MOV, c_S_IMM, c_D_A, 8'h80);
        rom[9] = ins(c_SUB, c_S_ONE, c_D_A, 8'h00);
        do_reset("t2");
        step();
        expect_val("t2_sub_a", c_K_A, 8'hFE);
        expect_val("t2_sub_flags", c_K_FLAGS, 4'b0110);
        step();
        expect_val("t2_addc_a", c_K_A, 8'h00);
        expect_val("t2_addc_flags", c_K_FLAGS, 4'b0101);
        step();
        expect_val("t2_or_a", c_K_A, 8'h0F);
        expect_val("t2_or_flags", c_K_FLAGS, 4'b0000);
        step();
        expect_val("t2_xor_flags", c_K_FLAGS, 4'b0001);
        step();
        expect_val("t2_movx_r2", c_K_R2, 8'hA5);
        expect_val("t2_movx_flags", c_K_FLAGS, 4'b0010);
        step();
        step();
        expect_val("t2_and_a", c_K_A, 8'h24);
        step();
        step();
        expect_val("t2_subv_a", c_K_A, 8'h7F);
        expect_val("t2_subv_flags", c_K_FLAGS, 4'b1000);
        expect_val("t2_pc", c_K_PC, 10);
        step();

        // Countdown loop: body runs three times, exits on Z
        clear_rom();
        rom[0] = ins(c_MOV, c_S_IMM, c_D_R1, 8'd3);
        rom[1] = ins(c_MOV, c_S_R1,  c_D_A,  8'd0);
        rom[2] = ins(c_SUB, c_S_ONE, c_D_A,  8'd0);
        rom[3] = ins(c_MOV, c_S_A,   c_D_R1, 8'd0);
        rom[4] = ins(c_BR,  c_C_NZ,  2'd0,   8'd1);
        do_reset("t3");
        run_cycles(4);
        expect_val("t3_back1_pc", c_K_PC, 1);
        step();
        run_cycles(3);
        expect_val("t3_back2_pc", c_K_PC, 1);
        expect_val("t3_r1_mid", c_K_R1, 1);
        step();
        run_cycles(3);
        expect_val("t3_exit_pc", c_K_PC, 5);
        expect_val("t3_exit_r1", c_K_R1, 0);
        expect_val("t3_exit_flags", c_K_FLAGS, 4'b0001);
        step();
        expect_val("t3_halt", c_K_HALTED, 1);
        step();

        // Stall for four cycles, then HALT and hold, then reset
        clear_rom();
        rom[0] = ins(c_MOV, c_S_IMM, c_D_A, 8'd1);
        rom[1] = ins(c_ADD, c_S_ONE, c_D_A, 8'd0);
        rom[2] = ins(c_ADD, c_S_ONE, c_D_A, 8'd0);
        do_reset("t4");
        step();
        r_run = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_val("t4_stall_pc", c_K_PC, 1);
            expect_val("t4_stall_a", c_K_A, 1);
            step();
        end
        r_run = 1'b1;
        expect_val("t4_resume_a", c_K_A, 2);
        step();
        step();
        expect_val("t4_halt", c_K_HALTED, 1);
        step();
        for (int i = 0; i < 10; i++) begin
            expect_val("t4_hold_pc", c_K_PC, 3);
            expect_val("t4_hold_a", c_K_A, 3);
            step();
        end
        do_reset("t4b");
        expect_val("t4_restart_pc", c_K_PC, 1);
        step();

        // Straight-line code wraps pc from 31 to 0
        for (int i = 0; i < 32; i++) rom[i] = ins(c_ADD, c_S_ONE, c_D_A, 8'd0);
        do_reset("t5");
        run_cycles(29);
        expect_val("t5_pc30", c_K_PC, 30);
        step();
        expect_val("t5_pc31", c_K_PC, 31);
        step();
        expect_val("t5_pc0", c_K_PC, 0);
        expect_val("t5_a", c_K_A, 8'h20);
        step();

        // Condition codes, taken and not taken; BR keeps flags
        clear_rom();
        rom[0]  = ins(c_MOV, c_S_IMM, c_D_A, 8'hFF);
        rom[1]  = ins(c_ADD, c_S_ONE, c_D_A, 8'h00);
        rom[2]  = ins(c_BR,  c_C_C,   2'd0,  8'd5);
        rom[5]  = ins(c_BR,  c_C_NC,  2'd0,  8'd9);
        rom[6]  = ins(c_BR,  c_C_N,   2'd0,  8'd9);
        rom[7]  = ins(c_BR,  c_C_Z,   2'd0,  8'd10);
        rom[10] = ins(c_BR,  c_C_AL,  2'd0,  8'd20);
        rom[20] = ins(c_MOV, c_S_IMM, c_D_A, 8'h80);
        rom[21] = ins(c_BR,  c_C_N,   2'd0,  8'd25);
        rom[25] = ins(c_BR,  c_C_Z,   2'd0,  8'd0);
        rom[26] = ins(c_BR,  c_C_CALL, 2'd0, 8'h10);
        rom[27] = ins(c_BR,  c_C_RET, 2'd0,  8'h00);
        do_reset("t6");
        step();
        step();
        expect_val("t6_brc_pc", c_K_PC, 5);
        step();
        expect_val("t6_brnc_pc", c_K_PC, 6);
        expect_val("t6_br_flags", c_K_FLAGS, 4'b0101);
        step();
        expect_val("t6_brn_pc", c_K_PC, 7);
        step();
        expect_val("t6_brz_pc", c_K_PC, 10);
        step();
        expect_val("t6_bral_pc", c_K_PC, 20);
        step();
        step();
        expect_val("t6_brn2_pc", c_K_PC, 25);
        step();
        expect_val("t6_brz2_pc", c_K_PC, 26);
        step();
`ifndef DATAPATH_CALL_STACK_EN
        expect_val("t6_call_nt_pc", c_K_PC, 27);
        step();
        expect_val("t6_ret_nt_pc", c_K_PC, 28);
        expect_val("t6_err", c_K_ERR, 0);
        step();
`endif

        // CALL at pc=4 and RET
        clear_rom();
        for (int i = 0; i < 4; i++) rom[i] = ins(c_MOV, c_S_IMM, c_D_R3, 8'(i));
        rom[4]  = ins(c_BR, c_C_CALL, 2'd0, 8'h10);
        rom[16] = ins(c_BR, c_C_RET,  2'd0, 8'h00);
        do_reset("t7");
        run_cycles(4);
`ifdef DATAPATH_CALL_STACK_EN
        expect_val("t7_call_pc", c_K_PC, 16);
        step();
        expect_val("t7_ret_pc", c_K_PC, 5);
        expect_val("t7_err", c_K_ERR, 0);
        step();
`else
        expect_val("t7_call_nt_pc", c_K_PC, 5);
        step();
        expect_val("t7_halt", c_K_HALTED, 1);
        step();
`endif

        // Nested CALL/RET order
        clear_rom();
        rom[0]  = ins(c_BR, c_C_CALL, 2'd0, 8'd8);
        rom[8]  = ins(c_BR, c_C_CALL, 2'd0, 8'd12);
        rom[12] = ins(c_BR, c_C_RET,  2'd0, 8'd0);
        rom[9]  = ins(c_BR, c_C_RET,  2'd0, 8'd0);
        do_reset("t8");
`ifdef DATAPATH_CALL_STACK_EN
        expect_val("t8_call1_pc", c_K_PC, 8);
        step();
        expect_val("t8_call2_pc", c_K_PC, 12);
        step();
        expect_val("t8_ret1_pc", c_K_PC, 9);
        step();
        expect_val("t8_ret2_pc", c_K_PC, 1);
        expect_val("t8_err", c_K_ERR, 0);
        step();
`else
        expect_val("t8_call_nt_pc", c_K_PC, 1);
        step();
`endif

        // Third nested CALL overflows a two-deep stack
        rom[12] = ins(c_BR, c_C_CALL, 2'd0, 8'd16);
        do_reset("t9");
`ifdef DATAPATH_CALL_STACK_EN
        run_cycles(2);
        expect_val("t9_ovf_err", c_K_ERR, 1);
        expect_val("t9_ovf_halted", c_K_HALTED, 1);
        expect_val("t9_ovf_pc", c_K_PC, 12);
        step();
        expect_val("t9_ovf_hold_pc", c_K_PC, 12);
        step();
`else
        expect_val("t9_call_nt_pc", c_K_PC, 1);
        expect_val("t9_err", c_K_ERR, 0);
        step();
`endif

        // RET with nothing pushed
        clear_rom();
        rom[0] = ins(c_BR, c_C_RET, 2'd0, 8'd0);
        do_reset("t10");
`ifdef DATAPATH_CALL_STACK_EN
        expect_val("t10_unf_err", c_K_ERR, 1);
        expect_val("t10_unf_halted", c_K_HALTED, 1);
        expect_val("t10_unf_pc", c_K_PC, 0);
        step();
`else
        expect_val("t10_ret_nt_pc", c_K_PC, 1);
        expect_val("t10_err", c_K_ERR, 0);
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
